// File: rtl/alu_share_arbiter_if.sv
// Requester-side bundle for alu_share_arbiter: per-requester request payload and response handshake.
// Signal suffixes are relative to the arbiter (slave) side.
interface alu_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned OP_W    = 4
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ*OP_W-1:0]   req_op_i;
  logic [NUM_REQ*DATA_W-1:0] req_a_i;
  logic [NUM_REQ*DATA_W-1:0] req_b_i;
  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [NUM_REQ-1:0]        rsp_ready_i;
  logic [DATA_W-1:0]         rsp_data_o;
  logic                      rsp_zero_o;
  logic                      rsp_branch_o;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_zero_o, rsp_branch_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_zero_o, rsp_branch_o
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// One operation in flight: IDLE (grant) -> EXEC (ALU settles) -> RESP (hold result until ack).
module alu_share_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned OP_W    = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  alu_share_arbiter_if.slave  bus_io,
  output logic [DATA_W-1:0]   alu_data1_o,
  output logic [DATA_W-1:0]   alu_data2_o,
  output logic [OP_W-1:0]     alu_ctrl_o,
  input  logic [DATA_W-1:0]   alu_data_i,
  input  logic                alu_zero_i,
  input  logic                alu_branch_i,
  output logic                busy_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [OP_W-1:0] OpSub = OP_W'(1);
  localparam logic [OP_W-1:0] OpBlt = OP_W'(8);
  localparam logic [OP_W-1:0] OpBge = OP_W'(9);

  logic [1:0]         r_state;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   r_grant;
  logic [OP_W-1:0]    r_op;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_rsp_data;
  logic               r_rsp_zero;
  logic               r_rsp_branch;
  logic [NUM_REQ-1:0] r_rsp_valid;

  logic               w_found;
  logic [IDX_W-1:0]   w_winner;
  logic [IDX_W-1:0]   w_cand;
  logic [NUM_REQ-1:0] w_req_ready;

  // Search starts just after the last grant so priority rotates.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_cand = IDX_W'((32'(r_last_grant) + i) % NUM_REQ);
      if (!w_found && bus_io.req_valid_i[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_comb begin
    w_req_ready = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      w_req_ready[k] = (r_state == StIdle) && w_found && (w_winner == IDX_W'(k));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= StIdle;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_grant      <= '0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_data   <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_branch <= 1'b0;
      r_rsp_valid  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_op         <= bus_io.req_op_i[w_winner*OP_W +: OP_W];
            r_a          <= bus_io.req_a_i[w_winner*DATA_W +: DATA_W];
            r_b          <= bus_io.req_b_i[w_winner*DATA_W +: DATA_W];
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
            r_state      <= StExec;
          end
        end
        StExec: begin
          r_rsp_data   <= alu_data_i;
          // Flags are only meaningful for the ops that define them.
          r_rsp_zero   <= (r_op == OpSub) && alu_zero_i;
          r_rsp_branch <= ((r_op == OpBlt) || (r_op == OpBge)) && alu_branch_i;
          r_rsp_valid  <= NUM_REQ'(1) << r_grant;
          r_state      <= StResp;
        end
        StResp: begin
          if (bus_io.rsp_ready_i[r_grant]) begin
            r_rsp_valid <= '0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus_io.req_ready_o  = w_req_ready;
  assign bus_io.rsp_valid_o  = r_rsp_valid;
  assign bus_io.rsp_data_o   = r_rsp_data;
  assign bus_io.rsp_zero_o   = r_rsp_zero;
  assign bus_io.rsp_branch_o = r_rsp_branch;

  assign alu_data1_o = r_a;
  assign alu_data2_o = r_b;
  assign alu_ctrl_o  = r_op;
  assign busy_o      = (r_state != StIdle);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU attached to the alu_* ports.
module tb_alu_share_arbiter;
  localparam int unsigned NR = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW)) bus ();

  logic [DW-1:0] alu_d1, alu_d2, alu_data;
  logic [OW-1:0] alu_ctrl;
  logic          alu_zero, alu_branch, busy, force_branch;

  alu_share_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .bus_io       (bus),
    .alu_data1_o  (alu_d1),
    .alu_data2_o  (alu_d2),
    .alu_ctrl_o   (alu_ctrl),
    .alu_data_i   (alu_data),
    .alu_zero_i   (alu_zero),
    .alu_branch_i (alu_branch),
    .busy_o       (busy)
  );

  // External ALU stand-in; force_branch lets non-branch ops assert a spurious branch flag.
  always_comb begin
    alu_branch = force_branch;
    case (alu_ctrl)
      4'b0000: alu_data = alu_d1 + alu_d2;
      4'b0001: alu_data = alu_d1 - alu_d2;
      4'b0011: alu_data = alu_d1 ^ alu_d2;
      4'b1000: begin
        alu_data   = alu_d1 - alu_d2;
        alu_branch = $signed(alu_d1) < $signed(alu_d2);
      end
      4'b1001: begin
        alu_data   = alu_d1 - alu_d2;
        alu_branch = $signed(alu_d1) >= $signed(alu_d2);
      end
      4'b1111: alu_data = alu_d1 | alu_d2;
      default: alu_data = '0;
    endcase
    alu_zero = (alu_data == '0);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic set_req(input int k, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_op_i[k*OW +: OW] = op;
    bus.req_a_i[k*DW +: DW]  = a;
    bus.req_b_i[k*DW +: DW]  = b;
    bus.req_valid_i[k]       = 1'b1;
  endtask

  // Issues one request and returns in RESP at posedge+1; lat counts edges from ready to rsp_valid.
  task automatic run_op(input int k, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic ok, output int lat);
    logic acc;
    acc = 1'b0;
    ok  = 1'b0;
    lat = 0;
    set_req(k, op, a, b);
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.req_ready_o[k]) begin
        acc = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.req_valid_i[k] = 1'b0;
    if (acc) begin
      for (int c = 0; c < 10; c++) begin
        if (bus.rsp_valid_o[k]) begin
          ok = 1'b1;
          break;
        end
        @(posedge clk); #1;
        lat++;
      end
    end
  endtask

  task automatic finish_rsp(input int k);
    bus.rsp_ready_i[k] = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i[k] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_valid_i = '0; bus.rsp_ready_i = '0;
    bus.req_op_i = '0; bus.req_a_i = '0; bus.req_b_i = '0;
    force_branch = 1'b0;
    #3;
    n_checks++; if (bus.rsp_valid_o !== 2'b00) begin n_errors++; $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid_o); end
    n_checks++; if (bus.rsp_data_o !== 32'd0) begin n_errors++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data_o); end
    n_checks++; if ({bus.rsp_zero_o, bus.rsp_branch_o, busy} !== 3'b000) begin n_errors++; $display("FAIL reset_flags_busy got=%b exp=000", {bus.rsp_zero_o, bus.rsp_branch_o, busy}); end
    n_checks++; if ({alu_d1, alu_d2, alu_ctrl} !== 68'd0) begin n_errors++; $display("FAIL reset_alu_outs got=%h exp=0", {alu_d1, alu_d2, alu_ctrl}); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    set_req(0, 4'b0000, 32'd5, 32'd7);
    #1;
    n_checks++; if (bus.req_ready_o !== 2'b01) begin n_errors++; $display("FAIL t1_ready got=%b exp=01", bus.req_ready_o); end
    @(posedge clk); #1;
    bus.req_valid_i[0] = 1'b0;
    n_checks++; if ({busy, bus.rsp_valid_o, bus.req_ready_o} !== 5'b10000) begin n_errors++; $display("FAIL t1_exec got=%b exp=10000", {busy, bus.rsp_valid_o, bus.req_ready_o}); end
    n_checks++; if ({alu_d1, alu_d2, alu_ctrl} !== {32'd5, 32'd7, 4'b0000}) begin n_errors++; $display("FAIL t1_alu_in got=%h exp=%h", {alu_d1, alu_d2, alu_ctrl}, {32'd5, 32'd7, 4'b0000}); end
    @(posedge clk); #1;
    n_checks++; if (bus.rsp_valid_o !== 2'b01) begin n_errors++; $display("FAIL t1_rsp_valid got=%b exp=01", bus.rsp_valid_o); end
    n_checks++; if (bus.rsp_data_o !== 32'd12) begin n_errors++; $display("FAIL t1_data got=%0d exp=12", bus.rsp_data_o); end
    n_checks++; if ({bus.rsp_zero_o, bus.rsp_branch_o} !== 2'b00) begin n_errors++; $display("FAIL t1_flags got=%b exp=00", {bus.rsp_zero_o, bus.rsp_branch_o}); end
    finish_rsp(0);
    n_checks++; if ({busy, bus.rsp_valid_o} !== 3'b000) begin n_errors++; $display("FAIL t1_done got=%b exp=000", {busy, bus.rsp_valid_o}); end
  endtask

  task automatic test_sub_zero;
    logic ok; int lat;
    run_op(1, 4'b0001, 32'h1234, 32'h1234, ok, lat);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL sub_timeout got=%b exp=1", ok); end
    n_checks++; if (bus.rsp_valid_o !== 2'b10) begin n_errors++; $display("FAIL sub_rsp_valid got=%b exp=10", bus.rsp_valid_o); end
    n_checks++; if ({bus.rsp_data_o, bus.rsp_zero_o} !== {32'd0, 1'b1}) begin n_errors++; $display("FAIL sub_zero got=%h exp=%h", {bus.rsp_data_o, bus.rsp_zero_o}, {32'd0, 1'b1}); end
    finish_rsp(1);
    run_op(0, 4'b0000, 32'd0, 32'd0, ok, lat);
    n_checks++; if ({ok, bus.rsp_data_o, bus.rsp_zero_o} !== {1'b1, 32'd0, 1'b0}) begin n_errors++; $display("FAIL add_zero_masked got=%h exp=%h", {ok, bus.rsp_data_o, bus.rsp_zero_o}, {1'b1, 32'd0, 1'b0}); end
    finish_rsp(0);
  endtask

  task automatic test_branch;
    logic ok; int lat;
    force_branch = 1'b0;
    run_op(0, 4'b1000, 32'hFFFF_FFFF, 32'd1, ok, lat);
    n_checks++; if ({ok, bus.rsp_data_o, bus.rsp_branch_o, bus.rsp_zero_o} !== {1'b1, 32'hFFFF_FFFE, 2'b10}) begin n_errors++; $display("FAIL blt got=%h exp=%h", {ok, bus.rsp_data_o, bus.rsp_branch_o, bus.rsp_zero_o}, {1'b1, 32'hFFFF_FFFE, 2'b10}); end
    finish_rsp(0);
    run_op(0, 4'b1001, 32'hFFFF_FFFF, 32'd1, ok, lat);
    n_checks++; if ({ok, bus.rsp_branch_o} !== 2'b10) begin n_errors++; $display("FAIL bge got=%b exp=10", {ok, bus.rsp_branch_o}); end
    finish_rsp(0);
    force_branch = 1'b1;
    run_op(1, 4'b0011, 32'hFFFF_FFFF, 32'd1, ok, lat);
    n_checks++; if ({ok, bus.rsp_data_o, bus.rsp_branch_o} !== {1'b1, 32'hFFFF_FFFE, 1'b0}) begin n_errors++; $display("FAIL xor_branch_masked got=%h exp=%h", {ok, bus.rsp_data_o, bus.rsp_branch_o}, {1'b1, 32'hFFFF_FFFE, 1'b0}); end
    finish_rsp(1);
    run_op(1, 4'b1111, 32'd0, 32'd0, ok, lat);
    n_checks++; if ({ok, bus.rsp_data_o, bus.rsp_zero_o, bus.rsp_branch_o} !== {1'b1, 32'd0, 2'b00}) begin n_errors++; $display("FAIL passthru_op got=%h exp=%h", {ok, bus.rsp_data_o, bus.rsp_zero_o, bus.rsp_branch_o}, {1'b1, 32'd0, 2'b00}); end
    finish_rsp(1);
    force_branch = 1'b0;
  endtask

  task automatic test_round_robin;
    int grants[6];
    int at[6];
    int cnt;
    test_reset();
    cnt = 0;
    set_req(0, 4'b0000, 32'd1, 32'd1);
    set_req(1, 4'b0000, 32'd2, 32'd2);
    bus.rsp_ready_i = 2'b11;
    for (int cyc = 0; cyc < 60 && cnt < 6; cyc++) begin
      #1;
      if (bus.req_ready_o !== 2'b00) begin
        grants[cnt] = (bus.req_ready_o === 2'b01) ? 0 : (bus.req_ready_o === 2'b10) ? 1 : 99;
        at[cnt] = cyc;
        cnt++;
      end
      @(posedge clk); #1;
    end
    bus.req_valid_i = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    bus.rsp_ready_i = 2'b00;
    n_checks++; if (cnt !== 6) begin n_errors++; $display("FAIL rr_count got=%0d exp=6", cnt); end
    for (int i = 0; i < cnt; i++) begin
      n_checks++; if (grants[i] !== i % 2) begin n_errors++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, grants[i], i % 2); end
    end
    for (int i = 1; i < cnt; i++) begin
      n_checks++; if (at[i] - at[i-1] !== 3) begin n_errors++; $display("FAIL rr_spacing[%0d] got=%0d exp=3", i, at[i] - at[i-1]); end
    end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rr_idle got=%b exp=0", busy); end
  endtask

  task automatic test_stall;
    logic ok; int lat;
    run_op(0, 4'b0000, 32'd100, 32'd23, ok, lat);
    n_checks++; if ({ok, bus.rsp_data_o} !== {1'b1, 32'd123}) begin n_errors++; $display("FAIL stall_data got=%h exp=%h", {ok, bus.rsp_data_o}, {1'b1, 32'd123}); end
    n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL latency got=%0d exp=2", lat); end
    set_req(1, 4'b0001, 32'd777, 32'd1);
    bus.rsp_ready_i[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++; if ({bus.rsp_valid_o, bus.rsp_data_o, bus.req_ready_o, busy} !== {2'b01, 32'd123, 2'b00, 1'b1}) begin n_errors++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, {bus.rsp_valid_o, bus.rsp_data_o, bus.req_ready_o, busy}, {2'b01, 32'd123, 2'b00, 1'b1}); end
    end
    bus.rsp_ready_i[1] = 1'b0;
    finish_rsp(0);
    n_checks++; if ({bus.rsp_valid_o, busy, bus.req_ready_o} !== 5'b00010) begin n_errors++; $display("FAIL stall_release got=%b exp=00010", {bus.rsp_valid_o, busy, bus.req_ready_o}); end
    bus.req_valid_i[1] = 1'b0;
    #1;
    n_checks++; if (bus.req_ready_o !== 2'b00) begin n_errors++; $display("FAIL drop_ready got=%b exp=00", bus.req_ready_o); end
    @(posedge clk); #1;
    n_checks++; if ({busy, alu_d1} !== {1'b0, 32'd100}) begin n_errors++; $display("FAIL drop_no_latch got=%h exp=%h", {busy, alu_d1}, {1'b0, 32'd100}); end
  endtask

  task automatic test_reset_exec;
    set_req(0, 4'b0000, 32'd9, 32'd9);
    #1;
    @(posedge clk); #1;
    bus.req_valid_i[0] = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rx_in_exec got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, bus.rsp_valid_o, bus.rsp_data_o, alu_d1, alu_ctrl} !== 71'd0) begin n_errors++; $display("FAIL rx_async_clear got=%h exp=0", {busy, bus.rsp_valid_o, bus.rsp_data_o, alu_d1, alu_ctrl}); end
    #2;
    rst_n = 1'b1;
    bus.rsp_ready_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.rsp_valid_o !== 2'b00) begin n_errors++; $display("FAIL rx_no_rsp[%0d] got=%b exp=00", i, bus.rsp_valid_o); end
    end
    bus.rsp_ready_i = 2'b00;
    set_req(0, 4'b0000, 32'd1, 32'd1);
    set_req(1, 4'b0000, 32'd2, 32'd2);
    #1;
    n_checks++; if (bus.req_ready_o !== 2'b01) begin n_errors++; $display("FAIL rx_prio_restart got=%b exp=01", bus.req_ready_o); end
    bus.req_valid_i = 2'b00;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_sub_zero();
    test_branch();
    test_round_robin();
    test_stall();
    test_reset_exec();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
